// File: rtl/edge_bitmap_packer.sv
// Packs per-pixel edge flags into 32-bit LSB-first bitmap words with border masking,
// per-frame edge counting and a 4-deep first-word-fall-through output FIFO.
module edge_bitmap_packer #(
  parameter int LINE_W  = 800,
  parameter int FRAME_H = 600,
  parameter int BORDER  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pix_valid,
  input  logic        frame_start,
  input  logic        edge_in,
  output logic [31:0] word_data,
  output logic        word_eol,
  output logic        word_eof,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [19:0] edge_count,
  output logic        count_valid,
  output logic        overflow,
  output logic        frame_err
);

  localparam int CW = $clog2(LINE_W);
  localparam int RW = $clog2(FRAME_H);

  localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);
  localparam logic [CW-1:0] COL_LO   = CW'(BORDER);
  localparam logic [CW-1:0] COL_HI   = CW'(LINE_W - BORDER);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_H - 1);
  localparam logic [RW-1:0] ROW_LO   = RW'(BORDER);
  localparam logic [RW-1:0] ROW_HI   = RW'(FRAME_H - BORDER);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t         state_r, state_n;
  logic [CW-1:0]  col_r, col_n, pcol_s;
  logic [RW-1:0]  row_r, row_n, prow_s;
  logic [4:0]     bit_idx_r, bit_idx_n, pbit_s;
  logic [31:0]    shift_r, shift_n, base_word_s, cur_word_s;
  logic [19:0]    acc_r, acc_n, base_acc_s;
  logic [19:0]    edge_count_r;
  logic           count_valid_r, overflow_r, frame_err_r;

  logic           first_s, abort_s, take_s, eff_s;
  logic           line_end_s, frame_end_s, push_s;

  logic [33:0]    fifo_mem_r [4];
  logic [1:0]     wr_ptr_r, rd_ptr_r;
  logic [2:0]     fifo_cnt_r;
  logic           pop_s, wr_ok_s;

  // Pixel datapath: effective position, masking, packing, counting and next state.
  always_comb begin
    first_s     = pix_valid && frame_start && (state_r != ST_ACTIVE);
    abort_s     = pix_valid && frame_start && (state_r == ST_ACTIVE);
    take_s      = pix_valid && ((state_r == ST_ACTIVE) || first_s);
    pcol_s      = col_r;
    prow_s      = row_r;
    pbit_s      = bit_idx_r;
    base_word_s = shift_r;
    base_acc_s  = acc_r;
    state_n     = state_r;
    col_n       = col_r;
    row_n       = row_r;
    bit_idx_n   = bit_idx_r;
    shift_n     = shift_r;
    acc_n       = acc_r;

    // A frame start (fresh or aborting) makes this pixel position (0,0) of a clean frame.
    if (first_s || abort_s) begin
      pcol_s      = '0;
      prow_s      = '0;
      pbit_s      = 5'd0;
      base_word_s = 32'd0;
      base_acc_s  = 20'd0;
    end else begin
      pcol_s      = col_r;
      prow_s      = row_r;
      pbit_s      = bit_idx_r;
      base_word_s = shift_r;
      base_acc_s  = acc_r;
    end

    eff_s       = edge_in && (pcol_s >= COL_LO) && (pcol_s < COL_HI) &&
                  (prow_s >= ROW_LO) && (prow_s < ROW_HI);
    cur_word_s  = base_word_s | ({31'd0, eff_s} << pbit_s);
    line_end_s  = (pcol_s == COL_LAST);
    frame_end_s = line_end_s && (prow_s == ROW_LAST);
    push_s      = take_s && ((pbit_s == 5'd31) || line_end_s);

    if (take_s) begin
      bit_idx_n = push_s ? 5'd0 : (pbit_s + 5'd1);
      shift_n   = push_s ? 32'd0 : cur_word_s;
      if (eff_s && (base_acc_s != 20'hFFFFF)) begin
        acc_n = base_acc_s + 20'd1;
      end else begin
        acc_n = base_acc_s;
      end
      if (line_end_s) begin
        col_n = '0;
        row_n = frame_end_s ? '0 : (prow_s + RW'(1));
      end else begin
        col_n = pcol_s + CW'(1);
        row_n = prow_s;
      end
    end else begin
      bit_idx_n = bit_idx_r;
      shift_n   = shift_r;
      acc_n     = acc_r;
      col_n     = col_r;
      row_n     = row_r;
    end

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (first_s) begin
          state_n = frame_end_s ? ST_DONE : ST_ACTIVE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (take_s && frame_end_s) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_ACTIVE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // FIFO handshake: a pop in the same cycle frees the slot for a push into a full FIFO.
  always_comb begin
    pop_s   = (fifo_cnt_r != 3'd0) && word_ready;
    wr_ok_s = push_s && ((fifo_cnt_r != 3'd4) || pop_s);
  end

  // Frame state, position counters, shift word and edge accumulator.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      col_r     <= '0;
      row_r     <= '0;
      bit_idx_r <= 5'd0;
      shift_r   <= 32'd0;
      acc_r     <= 20'd0;
    end else begin
      state_r   <= state_n;
      col_r     <= col_n;
      row_r     <= row_n;
      bit_idx_r <= bit_idx_n;
      shift_r   <= shift_n;
      acc_r     <= acc_n;
    end
  end

  // Output word FIFO storage and pointers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem_r[i] <= 34'd0;
      end
      wr_ptr_r   <= 2'd0;
      rd_ptr_r   <= 2'd0;
      fifo_cnt_r <= 3'd0;
    end else begin
      if (wr_ok_s) begin
        fifo_mem_r[wr_ptr_r] <= {frame_end_s, line_end_s, cur_word_s};
        wr_ptr_r             <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      fifo_cnt_r <= fifo_cnt_r + {2'd0, wr_ok_s} - {2'd0, pop_s};
    end
  end

  // Frame result and sticky status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      edge_count_r  <= 20'd0;
      count_valid_r <= 1'b0;
      overflow_r    <= 1'b0;
      frame_err_r   <= 1'b0;
    end else begin
      count_valid_r <= take_s && frame_end_s;
      if (take_s && frame_end_s) begin
        edge_count_r <= acc_n;
      end
      if (push_s && !wr_ok_s) begin
        overflow_r <= 1'b1;
      end else if (first_s) begin
        overflow_r <= 1'b0;
      end
      if (abort_s) begin
        frame_err_r <= 1'b1;
      end else if (first_s) begin
        frame_err_r <= 1'b0;
      end
    end
  end

  assign word_data   = fifo_mem_r[rd_ptr_r][31:0];
  assign word_eol    = fifo_mem_r[rd_ptr_r][32];
  assign word_eof    = fifo_mem_r[rd_ptr_r][33];
  assign word_valid  = (fifo_cnt_r != 3'd0);
  assign edge_count  = edge_count_r;
  assign count_valid = count_valid_r;
  assign overflow    = overflow_r;
  assign frame_err   = frame_err_r;

endmodule
